euler_step_sequencer: RTL
=========================

Name: euler_step_sequencer

Overview:
Consumer side of the Euler start handshake. Accepts the one-cycle start pulse produced by the start FSM and runs the Euler iteration loop. It issues one step request per iteration to the step datapath and waits for that datapath's acknowledge. It advances the time register by h and returns a one-cycle final_done pulse to the start FSM when the run ends: step budget spent, t_end reached, or abort.

Parameters:
DW, 16, width of time values t0, h, t_end, step_t (unsigned fixed-point)
CW, 12, width of step counter and num_steps

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, one clock; reset is asynchronous and active-low
start  input  1  one-cycle start pulse from start FSM
abort  input  1  terminate run early
num_steps  input  CW  maximum step count, sampled on accepted start
t0  input  DW  initial time, sampled on accepted start
h  input  DW  step size, sampled on accepted start
t_end  input  DW  end time, sampled on accepted start
step_req  output  1  one-cycle request to step datapath
step_t  output  DW  time of current step, valid while step_req=1
step_ack  input  1  step datapath finished current step
step_idx  output  CW  index of the step in flight (0-based)
busy  output  1  high from accepted start until final_done cycle inclusive
final_done  output  1  one-cycle completion pulse to start FSM
aborted  output  1  status of last run: 1 if it ended by abort, held until next accepted start

Behaviour:
- All outputs registered (Moore); none combinational from inputs.
- Reset (async, rst_n=0): state=IDLE; step_req=0, final_done=0, busy=0, aborted=0, step_idx=0, step_t=0; latched t0/h/t_end/num_steps cleared. Reset mid-run discards the run and produces no final_done.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: busy=0. start=1 is accepted here only. On accept: latch num_steps, h, t_end; t<=t0; step_idx<=0; aborted<=0.
  - If num_steps==0 or t0>=t_end -> DONE.
  - Otherwise -> ISSUE.
- ISSUE: step_req=1 for exactly this cycle; step_t=t. Next state is WAIT. step_ack in ISSUE is ignored.
- WAIT: step_req=0. On step_ack=1:
  - sum = t+h computed at DW+1 bits; t<=sum[DW-1:0].
  - If step_idx+1==num_steps, or sum>=t_end, or sum[DW]=1 (overflow) -> DONE.
  - Otherwise step_idx<=step_idx+1 and -> ISSUE.
  - With no ack, stay in WAIT indefinitely.
- abort=1 in ISSUE or WAIT -> DONE with aborted<=1. Abort takes priority over a simultaneous step_ack; that step is not counted and t is not advanced. abort in IDLE or DONE is ignored.
- DONE: final_done=1 for exactly one cycle, busy=1; next state is IDLE.
- start while busy (ISSUE, WAIT, DONE) is ignored, not queued.
- Latency:
  - start accepted at edge N -> step_req high in cycle N+1.
  - ack accepted at edge M -> next step_req in cycle M+1, or final_done in cycle M+1.
  - Minimum per-step period: 2 cycles (ISSUE, WAIT with immediate ack).
- step_idx holds its last value after the run; it is reset only by an accepted start.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-cycle -> all outputs 0 immediately. Release, then start with t0=0, h=1, t_end=100, num_steps=3, ack 1 cycle after each req -> exactly 3 step_req pulses with step_t=0,1,2; one final_done; aborted=0.
- t_end bound: t0=10, h=4, t_end=20, num_steps=50 -> step_t=10,14,18; final_done after 3rd ack (sum=22>=20).
- Zero work: num_steps=0 -> no step_req; final_done 2 cycles after start. Separately t0=30, t_end=20 -> same result.
- Abort: abort asserted in the same cycle as the 2nd step_ack -> final_done next cycle; aborted=1; only 1 step counted (step_idx=1); no further step_req.
- Overflow: DW=16, t0=0xFFF0, h=0x20, t_end=0xFFFF, num_steps=10 -> 1 step_req; final_done after 1st ack.
- Robustness: start pulsed during WAIT -> ignored, run completes normally. Ack held high continuously -> steps advance every 2 cycles. Reset in WAIT -> no final_done; IDLE after release.

Source files
------------

// File: rtl/euler_step_sequencer.sv
// Euler step sequencer: takes the start pulse from the start FSM, issues one
// step request per iteration to the step datapath, advances time by h on each
// acknowledge, and returns a one-cycle final_done when the run ends (step
// budget spent, t_end reached, time overflow, or abort).
module euler_step_sequencer #(
    parameter int DW = 16,
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] num_steps,
    input  logic [DW-1:0] t0,
    input  logic [DW-1:0] h,
    input  logic [DW-1:0] t_end,
    output logic          step_req,
    output logic [DW-1:0] step_t,
    input  logic          step_ack,
    output logic [CW-1:0] step_idx,
    output logic          busy,
    output logic          final_done,
    output logic          aborted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] t_q, t_d;
    logic [DW-1:0] h_q, h_d;
    logic [DW-1:0] t_end_q, t_end_d;
    logic [CW-1:0] nsteps_q, nsteps_d;
    logic [CW-1:0] step_idx_q, step_idx_d;
    logic          aborted_q, aborted_d;
    logic          step_req_q, step_req_d;
    logic [DW-1:0] step_t_q, step_t_d;
    logic          busy_q, busy_d;
    logic          final_done_q, final_done_d;

    // One extra bit on the sum so an overflowing time step ends the run
    // instead of wrapping back below t_end.
    logic [DW:0]   sum_s;
    logic [CW-1:0] idx_inc_s;

    assign sum_s     = {1'b0, t_q} + {1'b0, h_q};
    assign idx_inc_s = step_idx_q + CW'(1);

    // Next-state and next-output logic; outputs are decoded from the next
    // state so every output leaves a flop.
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        h_d        = h_q;
        t_end_d    = t_end_q;
        nsteps_d   = nsteps_q;
        step_idx_d = step_idx_q;
        aborted_d  = aborted_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    nsteps_d   = num_steps;
                    h_d        = h;
                    t_end_d    = t_end;
                    t_d        = t0;
                    step_idx_d = {CW{1'b0}};
                    aborted_d  = 1'b0;
                    if ((num_steps == {CW{1'b0}}) || (t0 >= t_end)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // An ack arriving in the request cycle belongs to no step yet.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Abort wins over a coincident ack: that step is not counted.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (step_ack) begin
                    t_d = sum_s[DW-1:0];
                    if ((idx_inc_s == nsteps_q) || (sum_s >= {1'b0, t_end_q}) || sum_s[DW]) begin
                        state_d = DONE;
                    end else begin
                        step_idx_d = idx_inc_s;
                        state_d    = ISSUE;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        step_req_d   = (state_d == ISSUE);
        busy_d       = (state_d != IDLE);
        final_done_d = (state_d == DONE);
        if (state_d == ISSUE) begin
            step_t_d = t_d;
        end else begin
            step_t_d = step_t_q;
        end
    end

    // State, run context and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            t_q          <= {DW{1'b0}};
            h_q          <= {DW{1'b0}};
            t_end_q      <= {DW{1'b0}};
            nsteps_q     <= {CW{1'b0}};
            step_idx_q   <= {CW{1'b0}};
            aborted_q    <= 1'b0;
            step_req_q   <= 1'b0;
            step_t_q     <= {DW{1'b0}};
            busy_q       <= 1'b0;
            final_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            h_q          <= h_d;
            t_end_q      <= t_end_d;
            nsteps_q     <= nsteps_d;
            step_idx_q   <= step_idx_d;
            aborted_q    <= aborted_d;
            step_req_q   <= step_req_d;
            step_t_q     <= step_t_d;
            busy_q       <= busy_d;
            final_done_q <= final_done_d;
        end
    end

    assign step_req   = step_req_q;
    assign step_t     = step_t_q;
    assign step_idx   = step_idx_q;
    assign busy       = busy_q;
    assign final_done = final_done_q;
    assign aborted    = aborted_q;

endmodule
